// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: jbs bit map, forward
// selects, dmem FSM states and the per-stage shadow record.
package pipe_ctrl_pkg;
  localparam int RA_W  = 5;
  localparam int JBS_W = 10;

  localparam int JB_BEQ   = 9;
  localparam int JB_BNE   = 8;
  localparam int JB_BLT   = 7;
  localparam int JB_BGE   = 6;
  localparam int JB_BLTU  = 5;
  localparam int JB_BGEU  = 4;
  localparam int JB_JAL   = 3;
  localparam int JB_JALR  = 2;
  localparam int JB_LUI   = 1;
  localparam int JB_AUIPC = 0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_e;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mstate_e;

  typedef struct packed {
    logic             valid;
    logic [RA_W-1:0]  rd;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic             wen;
    logic             mem_rd;
    logic             mem_wr;
    logic [JBS_W-1:0] jbs;
  } stage_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder-side inputs and sequencing outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int JB_W   = 10
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_w_n;
  logic              id_mem_read;
  logic              id_mem_write;
  logic [JB_W-1:0]   id_jbs;
  logic              ex_cond_true;
  logic              dmem_ack;

  logic              pc_stall;
  logic              if_id_stall;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              ex_mem_stall;
  logic              mem_wb_bubble;
  logic              redirect;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              dmem_req;
  logic              mem_timeout;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_w_n, id_mem_read, id_mem_write,
           id_jbs, ex_cond_true, dmem_ack,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
           mem_wb_bubble, redirect, fwd_a_sel, fwd_b_sel, dmem_req, mem_timeout
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_w_n, id_mem_read, id_mem_write,
           id_jbs, ex_cond_true, dmem_ack,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
           mem_wb_bubble, redirect, fwd_a_sel, fwd_b_sel, dmem_req, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl_dmem_wait_fsm.sv
// Data-memory req/ack handshake: freezes the pipe while an access is
// outstanding and force-completes it after TIMEOUT stall cycles.
module dmem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_timeout
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mstate_e       state;
  logic [CW-1:0] cnt;
  logic          expire;

  // Last wait cycle: the IDLE miss cycle plus TIMEOUT-1 waits make TIMEOUT stalls.
  assign expire = (state == M_WAIT) & (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    dmem_req  = (state == M_WAIT) | mem_op;
    mem_stall = (state == M_WAIT) ? ~(dmem_ack | expire) : (mem_op & ~dmem_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= M_IDLE;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        M_IDLE: if (mem_op & ~dmem_ack) begin
          state <= M_WAIT;
          cnt   <= '0;
        end
        M_WAIT: if (dmem_ack) begin
          state <= M_IDLE;
        end else if (expire) begin
          state       <= M_IDLE;
          mem_timeout <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      endcase
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipe: shadows rd and
// control bits through EX/MEM/WB and derives stall, flush, redirect, forwarding.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = RA_W,
  parameter int JB_W    = JBS_W,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);
  stage_t s_id, s_ex, s_mem, s_wb;
  logic   mem_op, mem_stall, load_use, lu_act, redir, bubble;

  always_comb begin
    s_id        = '0;
    s_id.valid  = bus.id_valid;
    s_id.rd     = bus.id_rd;
    s_id.rs1    = bus.id_rs1;
    s_id.rs2    = bus.id_rs2;
    s_id.wen    = ~bus.id_reg_w_n & (bus.id_rd != '0);
    s_id.mem_rd = bus.id_mem_read;
    s_id.mem_wr = bus.id_mem_write;
    s_id.jbs    = bus.id_jbs;
  end

  assign mem_op = s_mem.valid & (s_mem.mem_rd | s_mem.mem_wr);

  dmem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_dmem (
    .clk         (clk),
    .rst         (rst),
    .mem_op      (mem_op),
    .dmem_ack    (bus.dmem_ack),
    .dmem_req    (bus.dmem_req),
    .mem_stall   (mem_stall),
    .mem_timeout (bus.mem_timeout)
  );

  assign redir = s_ex.valid & ~mem_stall &
                 (s_ex.jbs[JB_JAL] | s_ex.jbs[JB_JALR] |
                  ((|s_ex.jbs[JB_W-1:JB_BGEU]) & bus.ex_cond_true));

  // rs2 is compared even for opcodes without one; a spurious stall is harmless.
  assign load_use = bus.id_valid & s_ex.valid & s_ex.mem_rd & s_ex.wen &
                    ((s_ex.rd == bus.id_rs1) | (s_ex.rd == bus.id_rs2));
  assign lu_act   = load_use & ~mem_stall & ~redir;
  assign bubble   = lu_act | redir;

  assign bus.pc_stall      = mem_stall | lu_act;
  assign bus.if_id_stall   = mem_stall | lu_act;
  assign bus.if_id_flush   = redir;
  assign bus.id_ex_bubble  = bubble;
  assign bus.ex_mem_stall  = mem_stall;
  assign bus.mem_wb_bubble = mem_stall;
  assign bus.redirect      = redir;

  // Load results are not ready in MEM, so only ALU results forward from there.
  function automatic fwd_e fwd_sel(input logic [REG_AW-1:0] r, input stage_t m, input stage_t w);
    if (m.valid & m.wen & ~m.mem_rd & (m.rd == r)) return FWD_EXMEM;
    if (w.valid & w.wen & (w.rd == r))             return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign bus.fwd_a_sel = fwd_sel(s_ex.rs1, s_mem, s_wb);
  assign bus.fwd_b_sel = fwd_sel(s_ex.rs2, s_mem, s_wb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ex  <= '0;
      s_mem <= '0;
      s_wb  <= '0;
    end else if (mem_stall) begin
      s_wb <= '0;
    end else begin
      s_ex  <= bubble ? '0 : s_id;
      s_mem <= s_ex;
      s_wb  <= s_mem;
    end
  end

  logic unused_wb;
  assign unused_wb = ^{s_wb.rs1, s_wb.rs2, s_wb.mem_rd, s_wb.mem_wr, s_wb.jbs};
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage RV32I pipeline around the instruction decoder.
- Consumes the ID-stage decoder outputs and carries its own shadow of rd/control bits through EX, MEM and WB.
- Generates stall, flush, redirect and forwarding selects.
- Runs the data-memory req/ack handshake FSM that freezes the pipeline on multi-cycle accesses.

Parameters:
- REG_AW, 5, register address width.
- JB_W, 10, width of decoder jump/branch flag vector {beq,bne,blt,bge,bltu,bgeu,jal,jalr,lui,auipc}, beq = MSB.
- TIMEOUT, 15, maximum dmem wait cycles before forced completion.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1 / id_rs2 / id_rd  in  5 each  decoder register fields.
- id_reg_w_n  in  1  decoder reg_w_ctrl; 1 = no rd write.
- id_mem_read / id_mem_write  in  1 each  decoder mem controls.
- id_jbs  in  10  decoder jbs_flag_cache.
- ex_cond_true  in  1  branch comparison result for the instruction in EX.
- dmem_ack  in  1  data memory completes this cycle.
- pc_stall / if_id_stall  out  1 each  hold PC and IF/ID.
- if_id_flush  out  1  kill the instruction in IF/ID.
- id_ex_bubble  out  1  load zeros into ID/EX.
- ex_mem_stall / mem_wb_bubble  out  1 each  freeze EX/MEM; inject a bubble into WB.
- redirect  out  1  PC takes the EX branch/jump target.
- fwd_a_sel / fwd_b_sel  out  2 each  EX operand source: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
- dmem_req  out  1  data memory request.
- mem_timeout  out  1  sticky; an access was force-completed.

Behaviour:
- Reset: all stage shadows (valid, rd, rs1, rs2, wen, mem_rd, mem_wr, jbs) are cleared. FSM goes to M_IDLE, the wait counter clears, and all outputs are 0.
- Shadow advance, each clk edge:
  - ID→EX, unless mem_stall holds it.
  - EX gets a bubble (valid = 0) on load-use or redirect.
  - EX→MEM and MEM→WB, unless mem_stall.
  - wen = ~reg_w_n & (rd != 0).
- Load-use:
  - Condition: id_valid & ex.valid & ex.mem_rd & ex.wen & (ex.rd == id_rs1 | ex.rd == id_rs2). rs2 is compared for every opcode, which is conservative.
  - Response: pc_stall, if_id_stall and id_ex_bubble are asserted for exactly 1 cycle.
- Redirect:
  - Condition: ex.valid & (jal | jalr | (any branch flag & ex_cond_true)) & ~mem_stall.
  - Response: redirect, if_id_flush and id_ex_bubble.
  - Redirect overrides load-use; pc_stall and if_id_stall are deasserted that cycle.
- Forwarding (for the EX operand, X = rs1 for fwd_a_sel or rs2 for fwd_b_sel):
  - 01 if mem.valid & mem.wen & ~mem.mem_rd & mem.rd == ex.X.
  - Otherwise 10 if wb.valid & wb.wen & wb.rd == ex.X.
  - Otherwise 00. MEM has priority over WB.
- dmem FSM, M_IDLE / M_WAIT:
  - mem_op = mem.valid & (mem_rd | mem_wr).
  - M_IDLE: dmem_req = mem_op. If dmem_ack arrives in the same cycle there is no stall. Otherwise go to M_WAIT, clear the counter, and assert mem_stall.
  - M_WAIT: dmem_req = 1 and mem_stall = 1; the counter increments.
    - On dmem_ack: return to M_IDLE, deassert mem_stall combinationally, and MEM advances.
    - When the counter reaches TIMEOUT: the access is force-completed as if acked and mem_timeout is set.
- mem_stall drives pc_stall, if_id_stall, ex_mem_stall and mem_wb_bubble; it blocks redirect and load-use actions that cycle.
- Reset in M_WAIT returns the FSM to M_IDLE immediately and drops dmem_req.
- dmem_ack while in M_IDLE with no mem_op is ignored.
- Outputs are combinational from state and inputs; there is no added latency.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - jbs bit indices (JB_BEQ = 9 … JB_AUIPC = 0);
  - FWD_RF / FWD_EXMEM / FWD_MEMWB encodings;
  - M_IDLE / M_WAIT state encoding;
  - the stage-shadow struct.
- One sub-module, dmem_wait_fsm, holds the FSM, the counter and the timeout; the rest stays in the top.

Test Plan:
- lw x5 in EX, add x6,x5,x1 in ID → pc_stall/if_id_stall/id_ex_bubble = 1 for 1 cycle, then fwd_a_sel = 10.
- add x5 in MEM, sub x7,x5,x5 in EX, add x5 also in WB → fwd_a_sel = fwd_b_sel = 01. With rd = x0 instead → 00.
- beq in EX with ex_cond_true = 1 and a lw-dependent instruction in ID → redirect = 1, if_id_flush = 1, no pc_stall. With ex_cond_true = 0 → no redirect.
- sw in MEM, dmem_ack 3 cycles late → dmem_req high 4 cycles, stalls for 3 cycles, mem_wb_bubble for 3, then advance.
- lw in MEM, ack never arrives → force-complete after 15 wait cycles, mem_timeout = 1 and stays set until rst.
- rst pulsed asynchronously mid M_WAIT → dmem_req = 0 and all outputs 0 before the next edge; no stalls after release.
